// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scancode decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int unsigned EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_key_decoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Drains PS/2 bytes, folds E0/F0 prefixes into key events, filters typematic
// repeats, tracks the held key and press count, and buffers events in a FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    output logic             nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [CNT_W-1:0] press_cnt,
    output logic             held,
    output logic [8:0]       held_code,
    output logic             err
);

    state_t           state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             held_q, held_d;
    logic [8:0]       held_code_q, held_code_d;
    logic             err_q, err_d;

    logic             consume;
    logic             ev_fire;
    logic             repeat_ev;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    ps2_event_t       push_ev;
    ps2_event_t       head_ev;

    always_comb begin
        state_d      = state_q;
        nextdata_n_d = 1'b1;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        press_cnt_d  = press_cnt_q;
        held_d       = held_q;
        held_code_d  = held_code_q;
        err_d        = err_q;

        consume   = (state_q == IDLE) && ps2_ready;
        ev_fire   = consume && (ps2_data != PS2_EXT) && (ps2_data != PS2_BRK);
        repeat_ev = !brk_pend_q && held_q && (held_code_q == {ext_pend_q, ps2_data});
        push      = ev_fire && !repeat_ev;
        pop       = !fifo_empty && ev_ready;
        push_ev   = '{ext: ext_pend_q, brk: brk_pend_q, code: ps2_data};

        unique case (state_q)
            IDLE: if (ps2_ready) begin
                state_d      = POP;
                nextdata_n_d = 1'b0;
            end
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (consume) begin
            if (ps2_data == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (ps2_data == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end

        // Key state follows the keyboard even when the FIFO drops the event.
        if (push) begin
            if (brk_pend_q) begin
                if (held_code_q == {ext_pend_q, ps2_data}) held_d = 1'b0;
            end else begin
                press_cnt_d = press_cnt_q + CNT_W'(1);
                held_d      = 1'b1;
                held_code_d = {ext_pend_q, ps2_data};
            end
            if (fifo_full && !pop) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            nextdata_n_q <= 1'b1;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            press_cnt_q  <= '0;
            held_q       <= 1'b0;
            held_code_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            press_cnt_q  <= press_cnt_d;
            held_q       <= held_d;
            held_code_q  <= held_code_d;
            err_q        <= err_d;
        end
    end

    sync_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_ev),
        .rd_en   (ev_ready),
        .rd_data (head_ev),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign nextdata_n = nextdata_n_q;
    assign ev_valid   = !fifo_empty;
    assign ev_code    = head_ev.code;
    assign ev_ext     = head_ev.ext;
    assign ev_break   = head_ev.brk;
    assign press_cnt  = press_cnt_q;
    assign held       = held_q;
    assign held_code  = held_code_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a default instance plus a CNT_W=3 instance for wrap.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ev_ready;

    logic       nextdata_n, ev_valid, ev_ext, ev_break, held, err;
    logic [7:0] ev_code, press_cnt;
    logic [8:0] held_code;

    logic       nextdata_n_w, ev_valid_w, ev_ext_w, ev_break_w, held_w, err_w;
    logic [7:0] ev_code_w;
    logic [2:0] press_cnt_w;
    logic [8:0] held_code_w;

    int vectors = 0;
    int errors  = 0;
    logic [9:0] captured [$];

    always #5 clk = ~clk;

    ps2_key_decoder #(.CNT_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .press_cnt(press_cnt), .held(held), .held_code(held_code), .err(err)
    );

    ps2_key_decoder #(.CNT_W(3), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n_w), .ev_valid(ev_valid_w), .ev_ready(ev_ready),
        .ev_code(ev_code_w), .ev_ext(ev_ext_w), .ev_break(ev_break_w),
        .press_cnt(press_cnt_w), .held(held_w), .held_code(held_code_w), .err(err_w)
    );

    // Record every event popped from the main instance, as {ext, brk, code}.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) captured.push_back({ev_ext, ev_break, ev_code});
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        captured.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        ps2_data = b; ps2_ready = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) break;
            n++;
        end
        vectors++;
        if (n >= 20) begin
            errors++;
            $display("FAIL pop_timeout byte=%h: nextdata_n never went low", b);
        end
        @(posedge clk); #1 ps2_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL pop_width byte=%h: nextdata_n=%b in gap, want 1", b, nextdata_n);
        end
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({nextdata_n, ev_valid, press_cnt, held, held_code, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 9'h000, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: nd=%b v=%b cnt=%h held=%b hc=%h err=%b, want 1 0 00 0 000 0",
                     nextdata_n, ev_valid, press_cnt, held, held_code, err);
        end
    endtask

    task automatic test_make_break();
        do_reset();
        ev_ready = 1'b1;
        send_byte(8'h15);
        vectors++;
        if ({held, held_code, press_cnt} !== {1'b1, 9'h015, 8'd1}) begin
            errors++;
            $display("FAIL mb_after_make: held=%b hc=%h cnt=%0d, want 1 015 1", held, held_code, press_cnt);
        end
        send_byte(8'hF0);
        send_byte(8'h15);
        drain();
        vectors++;
        if (held !== 1'b0 || press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mb_after_break: held=%b cnt=%0d, want 0 1", held, press_cnt);
        end
        vectors++;
        if (captured.size() != 2 || captured[0] !== 10'h015 || captured[1] !== 10'h115) begin
            errors++;
            $display("FAIL mb_events: n=%0d first=%h second=%h, want 2 015 115",
                     captured.size(), captured.size() > 0 ? captured[0] : 10'h3FF,
                     captured.size() > 1 ? captured[1] : 10'h3FF);
        end
    endtask

    task automatic test_typematic();
        do_reset();
        ev_ready = 1'b1;
        repeat (5) send_byte(8'h15);
        send_byte(8'hF0);
        send_byte(8'h15);
        drain();
        vectors++;
        if (captured.size() != 2 || captured[0] !== 10'h015 || captured[1] !== 10'h115) begin
            errors++;
            $display("FAIL typematic_events: n=%0d, want 2 events 015 115", captured.size());
        end
        vectors++;
        if (press_cnt !== 8'd1 || held !== 1'b0) begin
            errors++;
            $display("FAIL typematic_cnt: cnt=%0d held=%b, want 1 0", press_cnt, held);
        end
    endtask

    task automatic test_extended();
        do_reset();
        ev_ready = 1'b1;
        send_byte(8'hE0);
        send_byte(8'h75);
        vectors++;
        if (held !== 1'b1 || held_code !== 9'h175) begin
            errors++;
            $display("FAIL ext_held: held=%b hc=%h, want 1 175", held, held_code);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        drain();
        vectors++;
        if (captured.size() != 2 || captured[0] !== 10'h275 || captured[1] !== 10'h375 || held !== 1'b0) begin
            errors++;
            $display("FAIL ext_events: n=%0d held=%b, want 2 events 275 375 and held 0",
                     captured.size(), held);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [6] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_byte(codes[i]);
            if (i == 3) begin
                vectors++;
                if (err !== 1'b0 || ev_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_at_full: err=%b valid=%b, want 0 1", err, ev_valid);
                end
            end
            if (i == 4) begin
                vectors++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_err: err=%b after 5th make, want 1", err);
                end
            end
        end
        vectors++;
        if (press_cnt !== 8'd6 || held_code !== 9'h036) begin
            errors++;
            $display("FAIL ovf_cnt: cnt=%0d hc=%h, want 6 036", press_cnt, held_code);
        end
        ev_ready = 1'b1;
        drain();
        vectors++;
        if (captured.size() != 4 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain_count: n=%0d valid=%b, want 4 0", captured.size(), ev_valid);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (captured[i] !== {2'b00, codes[i]}) begin
                    errors++;
                    $display("FAIL ovf_order[%0d]: got %h want %h", i, captured[i], {2'b00, codes[i]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(codes[i]);
        // Push of the 5th event lands on the same edge as one pop while full.
        @(posedge clk); #1;
        ps2_data = codes[4]; ps2_ready = 1'b1; ev_ready = 1'b1;
        @(posedge clk); #1;
        ev_ready = 1'b0; ps2_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || press_cnt !== 8'd5) begin
            errors++;
            $display("FAIL b2b_no_drop: err=%b cnt=%0d, want 0 5", err, press_cnt);
        end
        ev_ready = 1'b1;
        drain();
        vectors++;
        if (captured.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: n=%0d, want 5", captured.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (captured[i] !== {2'b00, codes[i]}) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, captured[i], {2'b00, codes[i]});
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_byte(codes[i]);
            send_byte(8'hF0);
            send_byte(codes[i]);
        end
        drain();
        vectors++;
        if (press_cnt_w !== 3'd1) begin
            errors++;
            $display("FAIL wrap_cnt3: cnt=%0d, want 1", press_cnt_w);
        end
        vectors++;
        if (press_cnt !== 8'd9 || held !== 1'b0 || captured.size() != 18) begin
            errors++;
            $display("FAIL wrap_cnt8: cnt=%0d held=%b n=%0d, want 9 0 18", press_cnt, held, captured.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ev_ready = 1'b0;
        send_byte(8'h15);
        send_byte(8'hE0);
        do_reset();
        @(negedge clk);
        vectors++;
        if ({nextdata_n, ev_valid, press_cnt, held, held_code, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 9'h000, 1'b0}) begin
            errors++;
            $display("FAIL midrst_state: nd=%b v=%b cnt=%h held=%b hc=%h err=%b, want 1 0 00 0 000 0",
                     nextdata_n, ev_valid, press_cnt, held, held_code, err);
        end
        send_byte(8'h1C);
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b1 || {ev_ext, ev_break, ev_code} !== 10'h01C || held_code !== 9'h01C) begin
            errors++;
            $display("FAIL midrst_event: v=%b ev=%h hc=%h, want 1 01C 01C",
                     ev_valid, {ev_ext, ev_break, ev_code}, held_code);
        end
    endtask

    initial begin
        rst = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00; ev_ready = 1'b0;
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
